// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key-scheduling (swap) pass.
// Build option: KSA_SKIP_SELF_SWAP_EN (see ksa_swap_fsm.sv).
package ksa_pkg;

   localparam int KEY_LEN   = 3;
   localparam int MEM_DEPTH = 256;
   localparam int ADDR_W    = $clog2(MEM_DEPTH);
   localparam int KIDX_W    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

   typedef logic [7:0] byte_t;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_RD_I = 4'd1,
      S_WT_I = 4'd2,
      S_LD_I = 4'd3,
      S_WT_J = 4'd4,
      S_LD_J = 4'd5,
      S_WR_I = 4'd6,
      S_WR_J = 4'd7,
      S_DONE = 4'd8
   } state_t;

   // Big-endian byte select: index 0 is the most significant key byte.
   function automatic byte_t key_byte(input logic [8*KEY_LEN-1:0] key,
                                      input logic [KIDX_W-1:0]    idx);
      byte_t b;
      b = '0;
      for (int k = 0; k < KEY_LEN; k++) begin
         if (int'(idx) == k) b = key[8*(KEY_LEN-1-k) +: 8];
      end
      return b;
   endfunction

endpackage

// File: rtl/ksa_swap_fsm_key_byte_sel.sv
// Key byte selector: wrapping key index counter plus byte mux.
// The index counts 0..KEY_LEN-1 and wraps by compare, so no divider is needed.
module key_byte_sel
   import ksa_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  advance,
   input  logic [8*KEY_LEN-1:0]  key,
   output byte_t                 kbyte
);

   logic [KIDX_W-1:0] kidx_q, kidx_d;

   // Next key index: clear wins, otherwise step with wrap at KEY_LEN-1.
   always_comb begin
      kidx_d = kidx_q;
      if (clear) begin
         kidx_d = '0;
      end else if (advance) begin
         kidx_d = (kidx_q == KIDX_W'(KEY_LEN-1)) ? '0 : kidx_q + KIDX_W'(1);
      end
   end

   // Key index register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) kidx_q <= '0;
      else          kidx_q <= kidx_d;
   end

   assign kbyte = key_byte(key, kidx_q);

endmodule

// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling pass over a single-port 256x8 S memory that already
// holds S[i]=i. For i=0..255: j += S[i] + key[i mod KEY_LEN]; swap S[i],S[j].
// All outputs are registered; they are computed for the state being entered.
// Memory handshake: address is held for the whole state; the RAM samples it
// on the closing edge and q is used two states later (WT_x is the wait).
// Build option KSA_SKIP_SELF_SWAP_EN: when j==i the two writes are skipped
// and the iteration ends directly from LD_J (5 cycles instead of 7).
module ksa_swap_fsm
   import ksa_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [8*KEY_LEN-1:0]  secret_key,
   input  logic [7:0]            q,
   output logic [ADDR_W-1:0]     address,
   output logic [7:0]            data,
   output logic                  write_enable,
   output logic                  busy,
   output logic                  done,
   output state_t                dbg_state
);

   state_t                state_q, state_d;
   byte_t                 i_q, i_d;
   byte_t                 j_q, j_d;
   byte_t                 si_q, si_d;
   logic [8*KEY_LEN-1:0]  key_q, key_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   byte_t                 data_q, data_d;
   logic                  we_q, we_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  key_clear;
   logic                  key_adv;
   logic                  iter_exit;
   byte_t                 kbyte;
   byte_t                 j_sum;
   logic                  last_i;

   key_byte_sel u_key_sel (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (key_clear),
      .advance (key_adv),
      .key     (key_q),
      .kbyte   (kbyte)
   );

   assign j_sum  = j_q + q + kbyte;
   assign last_i = (i_q == byte_t'(MEM_DEPTH-1));

   // Next-state and registered-output computation.
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      si_d      = si_q;
      key_d     = key_q;
      addr_d    = addr_q;
      data_d    = data_q;
      we_d      = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      key_clear = 1'b0;
      key_adv   = 1'b0;
      iter_exit = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_RD_I;
               key_d     = secret_key;
               i_d       = '0;
               j_d       = '0;
               key_clear = 1'b1;
               addr_d    = '0;
               busy_d    = 1'b1;
            end
         end
         S_RD_I: state_d = S_WT_I;
         S_WT_I: state_d = S_LD_I;
         S_LD_I: begin
            si_d    = q;
            j_d     = j_sum;
            addr_d  = j_sum;
            state_d = S_WT_J;
         end
         S_WT_J: state_d = S_LD_J;
         S_LD_J: begin
`ifdef KSA_SKIP_SELF_SWAP_EN
            if (j_q == i_q) begin
               iter_exit = 1'b1;
            end else begin
               state_d = S_WR_I;
               addr_d  = i_q;
               data_d  = q;
               we_d    = 1'b1;
            end
`else
            state_d = S_WR_I;
            addr_d  = i_q;
            data_d  = q;
            we_d    = 1'b1;
`endif
         end
         S_WR_I: begin
            state_d = S_WR_J;
            addr_d  = j_q;
            data_d  = si_q;
            we_d    = 1'b1;
         end
         S_WR_J: iter_exit = 1'b1;
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // End of one swap iteration: finish after i==255, else move to i+1.
      if (iter_exit) begin
         if (last_i) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end else begin
            state_d = S_RD_I;
            i_d     = i_q + 8'd1;
            addr_d  = i_q + 8'd1;
            key_adv = 1'b1;
         end
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         si_q    <= '0;
         key_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         si_q    <= si_d;
         key_q   <= key_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign address      = addr_q;
   assign data         = data_q;
   assign write_enable = we_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Directed bench for ksa_swap_fsm with a 1-cycle-latency sync RAM model and
// a software RC4 key-schedule golden model.
`timescale 1ns/1ps
module tb_ksa_swap_fsm;
   import ksa_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [23:0] secret_key;
   logic [7:0]  q;
   logic [7:0]  address;
   logic [7:0]  data;
   logic        write_enable;
   logic        busy;
   logic        done;
   state_t      dbg_state;

   logic [7:0]  mem  [256];
   logic [7:0]  gold [256];
   logic [7:0]  snap [256];
   logic        load_req;

   int n_vec;
   int n_miss;

   // per-pass observations
   int   done_cyc, done_cnt, we_cnt, self_pairs;
   logic busy_c1, busy_at_done, idle_busy, post_busy, w7;
   logic [7:0] a4, a7, d7, first_wr_addr;

   ksa_swap_fsm dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .secret_key   (secret_key),
      .q            (q),
      .address      (address),
      .data         (data),
      .write_enable (write_enable),
      .busy         (busy),
      .done         (done),
      .dbg_state    (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // S memory model: sync write, registered read data, identity reload
   always @(posedge clk) begin
      if (load_req) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
      end else if (write_enable) begin
         mem[address] <= data;
      end
      q <= mem[address];
   end

   task automatic load_identity();
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic compute_golden(input logic [23:0] key, output int selfs);
      logic [7:0]  jj, t, kb;
      logic [23:0] sh;
      selfs = 0;
      jj    = 8'd0;
      for (int k = 0; k < 256; k++) gold[k] = 8'(k);
      for (int k = 0; k < 256; k++) begin
         sh = key >> (8 * (2 - (k % 3)));
         kb = sh[7:0];
         jj = jj + gold[k] + kb;
         if (jj == 8'(k)) selfs++;
         t        = gold[k];
         gold[k]  = gold[jj];
         gold[jj] = t;
      end
   endtask

   function automatic int count_bad(output int first_idx);
      int bad;
      bad = 0;
      first_idx = -1;
      for (int k = 0; k < 256; k++) begin
         if (mem[k] !== gold[k]) begin
            if (first_idx < 0) first_idx = k;
            bad++;
         end
      end
      return bad;
   endfunction

   // mode 0: plain pass; 1: restart pulse + key change at cycle 351 and a
   // start pulse in the done cycle; 2: assert reset at cycle 701 and return.
   task automatic run_pass(input logic [23:0] key, input int probe_cyc, input int mode);
      int c;
      bit fin;
      done_cyc = 0; done_cnt = 0; we_cnt = 0; self_pairs = 0;
      busy_c1 = 1'b0; busy_at_done = 1'b0; post_busy = 1'b0;
      a4 = 8'h00; a7 = 8'h00; d7 = 8'h00; w7 = 1'b0;
      @(negedge clk);
      idle_busy  = busy;
      secret_key = key;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c   = 1;
      fin = 1'b0;
      while (!fin) begin
         if (c == 1) busy_c1 = busy;
         if (c == 4) a4 = address;
         if (c == 7) begin a7 = address; d7 = data; w7 = write_enable; end
         if (write_enable) begin
            if (we_cnt % 2 == 0) first_wr_addr = address;
            else if (address == first_wr_addr) self_pairs++;
            we_cnt++;
         end
         if (done_cyc != 0 && c > done_cyc) post_busy = post_busy | busy;
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) begin done_cyc = c; busy_at_done = busy; end
         end
         if (c == probe_cyc) for (int k = 0; k < 256; k++) snap[k] = mem[k];
         start = (mode == 1) && (c == 351 || (done_cyc != 0 && c == done_cyc));
         if (mode == 1 && c == 351) secret_key = ~key;
         if (mode == 2 && c == 701) begin reset_n = 1'b0; fin = 1'b1; end
         if (done_cyc != 0 && c >= done_cyc + 4) fin = 1'b1;
         if (!fin && c >= 2100) begin
            n_vec++; n_miss++;
            $display("FAIL pass_timeout: no done after %0d cycles, required done by cycle 1793", c);
            fin = 1'b1;
         end
         if (!fin) begin @(negedge clk); c++; end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; secret_key = 24'h0; load_req = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (address !== 8'h00) begin n_miss++; $display("FAIL reset_address: got %h want 00", address); end
      n_vec++; if (data !== 8'h00) begin n_miss++; $display("FAIL reset_data: got %h want 00", data); end
      n_vec++; if (write_enable !== 1'b0) begin n_miss++; $display("FAIL reset_we: got %b want 0", write_enable); end
      n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b want 0", done); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL idle_busy_after_reset: got %b want 0", busy); end
   endtask

   task automatic test_zero_key();
      int selfs, bad, fi;
      load_identity();
      compute_golden(24'h000000, selfs);
      run_pass(24'h000000, 22, 0);
      n_vec++; if (snap[0] !== 8'd0) begin n_miss++; $display("FAIL k0_s0_after_i2: got %0d want 0", snap[0]); end
      n_vec++; if (snap[1] !== 8'd1) begin n_miss++; $display("FAIL k0_s1_after_i2: got %0d want 1", snap[1]); end
      n_vec++; if (snap[2] !== 8'd3) begin n_miss++; $display("FAIL k0_s2_after_i2: got %0d want 3", snap[2]); end
      n_vec++; if (snap[3] !== 8'd2) begin n_miss++; $display("FAIL k0_s3_after_i2: got %0d want 2", snap[3]); end
      bad = count_bad(fi);
      n_vec++; if (bad !== 0) begin n_miss++; $display("FAIL k0_final_s: %0d entries differ, first at %0d, want 0 differing", bad, fi); end
      n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL k0_done_pulses: got %0d want 1", done_cnt); end
   endtask

   task automatic test_key_010203();
      int selfs, bad, fi;
      load_identity();
      compute_golden(24'h010203, selfs);
      run_pass(24'h010203, 8, 0);
      n_vec++; if (snap[0] !== 8'd1) begin n_miss++; $display("FAIL k123_s0_after_i0: got %0d want 1", snap[0]); end
      n_vec++; if (snap[1] !== 8'd0) begin n_miss++; $display("FAIL k123_s1_after_i0: got %0d want 0", snap[1]); end
      n_vec++; if (a4 !== 8'd1) begin n_miss++; $display("FAIL k123_j_read_addr: got %0d want 1", a4); end
      n_vec++; if (w7 !== 1'b1) begin n_miss++; $display("FAIL k123_wr_j_we: got %b want 1", w7); end
      n_vec++; if (a7 !== 8'd1) begin n_miss++; $display("FAIL k123_wr_j_addr: got %0d want 1", a7); end
      n_vec++; if (d7 !== 8'd0) begin n_miss++; $display("FAIL k123_wr_j_data: got %0d want 0", d7); end
      bad = count_bad(fi);
      n_vec++; if (bad !== 0) begin n_miss++; $display("FAIL k123_final_s: %0d entries differ, first at %0d, want 0 differing", bad, fi); end
      n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL k123_done_pulses: got %0d want 1", done_cnt); end
   endtask

   task automatic test_timing();
      int selfs, exp_done, exp_we, exp_self;
      load_identity();
      compute_golden(24'h010203, selfs);
      run_pass(24'h010203, 0, 0);
`ifdef KSA_SKIP_SELF_SWAP_EN
      exp_done = 1793 - 2 * selfs;
      exp_we   = 512 - 2 * selfs;
      exp_self = 0;
`else
      exp_done = 1793;
      exp_we   = 512;
      exp_self = selfs;
`endif
      n_vec++; if (idle_busy !== 1'b0) begin n_miss++; $display("FAIL t_busy_before_start: got %b want 0", idle_busy); end
      n_vec++; if (busy_c1 !== 1'b1) begin n_miss++; $display("FAIL t_busy_cycle1: got %b want 1", busy_c1); end
      n_vec++; if (done_cyc !== exp_done) begin n_miss++; $display("FAIL t_done_cycle: got %0d want %0d", done_cyc, exp_done); end
      n_vec++; if (busy_at_done !== 1'b0) begin n_miss++; $display("FAIL t_busy_in_done: got %b want 0", busy_at_done); end
      n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL t_done_pulses: got %0d want 1", done_cnt); end
      n_vec++; if (we_cnt !== exp_we) begin n_miss++; $display("FAIL t_we_cycles: got %0d want %0d", we_cnt, exp_we); end
      n_vec++; if (self_pairs !== exp_self) begin n_miss++; $display("FAIL t_self_swap_writes: got %0d want %0d", self_pairs, exp_self); end
   endtask

   task automatic test_reset_mid_run();
      int selfs, bad, fi, we_seen, busy_seen;
      load_identity();
      run_pass(24'h010203, 0, 2);
      #1;
      n_vec++; if (address !== 8'h00) begin n_miss++; $display("FAIL mid_reset_address: got %h want 00", address); end
      n_vec++; if (data !== 8'h00) begin n_miss++; $display("FAIL mid_reset_data: got %h want 00", data); end
      n_vec++; if (write_enable !== 1'b0) begin n_miss++; $display("FAIL mid_reset_we: got %b want 0", write_enable); end
      n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL mid_reset_done: got %b want 0", done); end
      we_seen = 0; busy_seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 3) reset_n = 1'b1;
         we_seen   += int'(write_enable);
         busy_seen += int'(busy);
      end
      n_vec++; if (we_seen !== 0) begin n_miss++; $display("FAIL mid_reset_no_writes: got %0d write cycles want 0", we_seen); end
      n_vec++; if (busy_seen !== 0) begin n_miss++; $display("FAIL mid_reset_stays_idle: got %0d busy cycles want 0", busy_seen); end
      load_identity();
      compute_golden(24'h010203, selfs);
      run_pass(24'h010203, 0, 0);
      bad = count_bad(fi);
      n_vec++; if (bad !== 0) begin n_miss++; $display("FAIL rerun_final_s: %0d entries differ, first at %0d, want 0 differing", bad, fi); end
      n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL rerun_done_pulses: got %0d want 1", done_cnt); end
   endtask

   task automatic test_start_ignored();
      int selfs, bad, fi, exp_done;
      load_identity();
      compute_golden(24'h010203, selfs);
      run_pass(24'h010203, 0, 1);
`ifdef KSA_SKIP_SELF_SWAP_EN
      exp_done = 1793 - 2 * selfs;
`else
      exp_done = 1793;
`endif
      bad = count_bad(fi);
      n_vec++; if (bad !== 0) begin n_miss++; $display("FAIL perturb_final_s: %0d entries differ, first at %0d, want 0 differing", bad, fi); end
      n_vec++; if (done_cyc !== exp_done) begin n_miss++; $display("FAIL perturb_done_cycle: got %0d want %0d", done_cyc, exp_done); end
      n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL perturb_done_pulses: got %0d want 1", done_cnt); end
      n_vec++; if (post_busy !== 1'b0) begin n_miss++; $display("FAIL start_in_done_ignored: busy after done got %b want 0", post_busy); end
   endtask

`ifdef KSA_SKIP_SELF_SWAP_EN
   task automatic test_skip_self_swap();
      int selfs, bad, fi;
      load_identity();
      compute_golden(24'h000000, selfs);
      run_pass(24'h000000, 0, 0);
      bad = count_bad(fi);
      n_vec++; if (bad !== 0) begin n_miss++; $display("FAIL skip_final_s: %0d entries differ, first at %0d, want 0 differing", bad, fi); end
      n_vec++; if (done_cyc > 1789) begin n_miss++; $display("FAIL skip_done_early: got %0d want <= 1789", done_cyc); end
      n_vec++; if (done_cyc !== 1793 - 2 * selfs) begin n_miss++; $display("FAIL skip_done_cycle: got %0d want %0d", done_cyc, 1793 - 2 * selfs); end
      n_vec++; if (self_pairs !== 0) begin n_miss++; $display("FAIL skip_no_self_writes: got %0d want 0", self_pairs); end
      n_vec++; if (we_cnt !== 512 - 2 * selfs) begin n_miss++; $display("FAIL skip_we_cycles: got %0d want %0d", we_cnt, 512 - 2 * selfs); end
   endtask
`endif

   initial begin
      n_vec  = 0;
      n_miss = 0;
      test_reset();
      test_zero_key();
      test_key_010203();
      test_timing();
      test_reset_mid_run();
      test_start_ignored();
`ifdef KSA_SKIP_SELF_SWAP_EN
      test_skip_self_swap();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
